// File: rtl/mack_bus_controller.sv
// Mackerel 68000 bus controller: address decode with boot ROM overlay,
// internal/external DTACK generation and a BERR watchdog.
module mack_bus_controller #(
    parameter int unsigned BOOT_CYCLES  = 8,
    parameter logic [11:0] ROM_BASE     = 12'h380,
    parameter logic [11:0] ROM_MASK     = 12'hFC0,
    parameter logic [11:0] MFP_BASE     = 12'h3C0,
    parameter logic [11:0] MFP_MASK     = 12'hFC0,
    parameter logic [11:0] RAM_BASE     = 12'h000,
    parameter logic [11:0] RAM_MASK     = 12'hF80,
    parameter logic [11:0] EXP_BASE     = 12'h200,
    parameter logic [11:0] EXP_MASK     = 12'hF00,
    parameter int unsigned ROM_WS       = 1,
    parameter int unsigned RAM_WS       = 0,
    parameter int unsigned BERR_TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [11:0] i_addr,
    input  logic        i_as_n,
    input  logic        i_iack_n,
    input  logic        i_dtack_in_n,
    output logic        o_romen_n,
    output logic        o_ramen_n,
    output logic        o_mfpen_n,
    output logic        o_expen_n,
    output logic        o_dtack_n,
    output logic        o_berr_n,
    output logic        o_boot
);

    localparam int unsigned BW = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);
    localparam logic [BW-1:0] BOOT_MAX  = BW'(BOOT_CYCLES);
    localparam logic [BW-1:0] BOOT_LAST = BW'((BOOT_CYCLES == 0) ? 0 : BOOT_CYCLES - 1);
    localparam logic [7:0]    TO_LAST   = 8'(BERR_TIMEOUT - 1);
    localparam logic [3:0]    ROM_WAIT  = 4'(ROM_WS);
    localparam logic [3:0]    RAM_WAIT  = 4'(RAM_WS);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_FAULT} state_t;
    typedef enum logic [1:0] {CYC_INT, CYC_EXT, CYC_UNM} cyc_t;

    state_t        r_state;
    cyc_t          r_cyc;
    logic [3:0]    r_wcnt;
    logic [7:0]    r_tcnt;
    logic [BW-1:0] r_bcnt;
    logic          r_dtack_n;
    logic          r_berr_n;
    logic          r_boot;

    logic w_rom_hit, w_mfp_hit, w_ram_hit, w_exp_hit;
    logic w_rom_sel, w_mfp_sel, w_ram_sel, w_exp_sel;
    logic w_cs_en, w_ack, w_done;

    assign w_rom_hit = ((i_addr & ROM_MASK) == (ROM_BASE & ROM_MASK));
    assign w_mfp_hit = ((i_addr & MFP_MASK) == (MFP_BASE & MFP_MASK));
    assign w_ram_hit = ((i_addr & RAM_MASK) == (RAM_BASE & RAM_MASK));
    assign w_exp_hit = ((i_addr & EXP_MASK) == (EXP_BASE & EXP_MASK));

    // During the overlay every access lands in ROM; afterwards ROM > MFP > RAM > EXP.
    assign w_rom_sel = !r_boot || w_rom_hit;
    assign w_mfp_sel = r_boot && !w_rom_hit && w_mfp_hit;
    assign w_ram_sel = r_boot && !w_rom_hit && !w_mfp_hit && w_ram_hit;
    assign w_exp_sel = r_boot && !w_rom_hit && !w_mfp_hit && !w_ram_hit && w_exp_hit;

    assign w_cs_en   = !i_as_n && i_iack_n && i_rst_n;
    assign o_romen_n = !(w_cs_en && w_rom_sel);
    assign o_ramen_n = !(w_cs_en && w_ram_sel);
    assign o_mfpen_n = !(w_cs_en && w_mfp_sel);
    assign o_expen_n = !(w_cs_en && w_exp_sel);

    assign w_ack  = ((r_cyc == CYC_INT) && (r_wcnt == 4'd0)) ||
                    ((r_cyc == CYC_EXT) && !i_dtack_in_n);
    assign w_done = (r_state != ST_IDLE) && i_as_n;

    assign o_dtack_n = r_dtack_n;
    assign o_berr_n  = r_berr_n;
    assign o_boot    = r_boot;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_cyc     <= CYC_INT;
            r_wcnt    <= 4'd0;
            r_tcnt    <= 8'd0;
            r_bcnt    <= '0;
            r_dtack_n <= 1'b1;
            r_berr_n  <= 1'b1;
            r_boot    <= (BOOT_CYCLES == 0);
        end else begin
            if (w_done && (r_bcnt != BOOT_MAX))
                r_bcnt <= r_bcnt + 1'b1;
            if ((BOOT_CYCLES == 0) || (w_done && (r_bcnt == BOOT_LAST)))
                r_boot <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (!i_as_n) begin
                        r_state <= ST_WAIT;
                        r_tcnt  <= 8'd0;
                        r_wcnt  <= 4'd0;
                        if (!i_iack_n) begin
                            r_cyc <= CYC_EXT;
                        end else if (w_rom_sel) begin
                            r_cyc  <= CYC_INT;
                            r_wcnt <= ROM_WAIT;
                        end else if (w_ram_sel) begin
                            r_cyc  <= CYC_INT;
                            r_wcnt <= RAM_WAIT;
                        end else if (w_mfp_sel || w_exp_sel) begin
                            r_cyc <= CYC_EXT;
                        end else begin
                            r_cyc <= CYC_UNM;
                        end
                    end
                end
                // Acknowledge is tested before the watchdog so a same-edge race acks.
                ST_WAIT: begin
                    if (i_as_n) begin
                        r_state <= ST_IDLE;
                    end else if (w_ack) begin
                        r_state   <= ST_ACK;
                        r_dtack_n <= 1'b0;
                    end else if (r_tcnt == TO_LAST) begin
                        r_state  <= ST_FAULT;
                        r_berr_n <= 1'b0;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                        if (r_wcnt != 4'd0)
                            r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    if (i_as_n) begin
                        r_state   <= ST_IDLE;
                        r_dtack_n <= 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (i_as_n) begin
                        r_state  <= ST_IDLE;
                        r_berr_n <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mack_bus_controller.sv
// Directed bench for mack_bus_controller: boot overlay, region decode table,
// back-to-back strobes and mid-cycle reset.
module tb_mack_bus_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] addr;
    logic        as_n, iack_n, dtack_in_n;
    logic        romen_n, ramen_n, mfpen_n, expen_n;
    logic        dtack_n, berr_n, boot;

    int n_checks = 0;
    int n_errors = 0;

    mack_bus_controller dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_addr       (addr),
        .i_as_n       (as_n),
        .i_iack_n     (iack_n),
        .i_dtack_in_n (dtack_in_n),
        .o_romen_n    (romen_n),
        .o_ramen_n    (ramen_n),
        .o_mfpen_n    (mfpen_n),
        .o_expen_n    (expen_n),
        .o_dtack_n    (dtack_n),
        .o_berr_n     (berr_n),
        .o_boot       (boot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic        iack_n;
        int          dly;     // edge index at which DTACK_IN is first sampled low, -1 none
        bit          toggle;  // wiggle DTACK_IN every edge instead
        logic [3:0]  cs;      // {ROMEN, RAMEN, MFPEN, EXPEN}
        int          lat;     // edges after the AS-sampling edge until DTACK/BERR low
        bit          berr;
    } vec_t;

    vec_t tbl[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_cycle(input logic [11:0] a, input logic ia, input int dly, input bit toggle,
                             output logic [3:0] cs, output int lat, output bit got_berr,
                             output logic [1:0] rel);
        addr   = a;
        iack_n = ia;
        as_n   = 1'b0;
        #1;
        cs       = {romen_n, ramen_n, mfpen_n, expen_n};
        lat      = -1;
        got_berr = 1'b0;
        for (int n = 0; n < 300 && lat < 0; n++) begin
            if (toggle)
                dtack_in_n = (n % 2 == 0);
            else if (dly >= 0 && n == dly)
                dtack_in_n = 1'b0;
            tick();
            check("dtack_berr_exclusive", 32'(dtack_n | berr_n), 32'd1);
            if (!dtack_n) begin
                lat = n;
            end else if (!berr_n) begin
                lat      = n;
                got_berr = 1'b1;
            end
        end
        as_n       = 1'b1;
        dtack_in_n = 1'b1;
        iack_n     = 1'b1;
        tick();
        rel = {dtack_n, berr_n};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [3:0] cs;
        int         lat;
        bit         gb;
        logic [1:0] rel;

        tbl[0]  = '{12'h380, 1'b1, -1, 1'b1, 4'b0111,  2, 1'b0};
        tbl[1]  = '{12'h3C0, 1'b1,  5, 1'b0, 4'b1101,  5, 1'b0};
        tbl[2]  = '{12'h000, 1'b1, -1, 1'b1, 4'b1011,  1, 1'b0};
        tbl[3]  = '{12'h200, 1'b1,  3, 1'b0, 4'b1110,  3, 1'b0};
        tbl[4]  = '{12'h3C0, 1'b0,  2, 1'b0, 4'b1111,  2, 1'b0};
        tbl[5]  = '{12'h100, 1'b1, -1, 1'b0, 4'b1111, 64, 1'b1};
        tbl[6]  = '{12'h3FF, 1'b1,  1, 1'b0, 4'b1101,  1, 1'b0};
        tbl[7]  = '{12'h07F, 1'b1, -1, 1'b1, 4'b1011,  1, 1'b0};
        tbl[8]  = '{12'h080, 1'b1, -1, 1'b0, 4'b1111, 64, 1'b1};
        tbl[9]  = '{12'h2FF, 1'b1,  4, 1'b0, 4'b1110,  4, 1'b0};
        tbl[10] = '{12'h3C0, 1'b0, -1, 1'b0, 4'b1111, 64, 1'b1};
        tbl[11] = '{12'h200, 1'b1, 64, 1'b0, 4'b1110, 64, 1'b0};

        rst_n = 1'b0; as_n = 1'b1; iack_n = 1'b1; dtack_in_n = 1'b1; addr = 12'h000;
        tick();
        tick();
        check("rst_cs",    32'({romen_n, ramen_n, mfpen_n, expen_n}), 32'hF);
        check("rst_dtack", 32'(dtack_n), 32'd1);
        check("rst_berr",  32'(berr_n),  32'd1);
        check("rst_boot",  32'(boot),    32'd0);
        addr = 12'h380;
        as_n = 1'b0;
        #1;
        check("rst_gates_cs", 32'({romen_n, ramen_n, mfpen_n, expen_n}), 32'hF);
        as_n  = 1'b1;
        rst_n = 1'b1;
        tick();

        // Boot overlay: RAM addresses still select ROM with ROM wait states
        for (int i = 0; i < 8; i++) begin
            run_cycle(12'h000, 1'b1, -1, 1'b0, cs, lat, gb, rel);
            check($sformatf("boot%0d_cs", i),   32'(cs),  32'(4'b0111));
            check($sformatf("boot%0d_lat", i),  lat,      32'd2);
            check($sformatf("boot%0d_rel", i),  32'(rel), 32'd3);
            check($sformatf("boot%0d_boot", i), 32'(boot), (i == 7) ? 32'd1 : 32'd0);
        end
        run_cycle(12'h000, 1'b1, -1, 1'b0, cs, lat, gb, rel);
        check("post_boot_cs",   32'(cs),   32'(4'b1011));
        check("post_boot_lat",  lat,       32'd1);
        check("post_boot_boot", 32'(boot), 32'd1);

        for (int i = 0; i < 12; i++) begin
            run_cycle(tbl[i].addr, tbl[i].iack_n, tbl[i].dly, tbl[i].toggle, cs, lat, gb, rel);
            check($sformatf("row%0d_cs", i),   32'(cs),  32'(tbl[i].cs));
            check($sformatf("row%0d_lat", i),  lat,      tbl[i].lat);
            check($sformatf("row%0d_berr", i), 32'(gb),  32'(tbl[i].berr));
            check($sformatf("row%0d_rel", i),  32'(rel), 32'd3);
        end

        // AS bounces between edges while in ACK: FSM holds, selects follow AS
        addr = 12'h000;
        as_n = 1'b0;
        tick();
        tick();
        check("b2b_dtack", 32'(dtack_n), 32'd0);
        as_n = 1'b1;
        #1;
        check("b2b_cs_off", 32'({romen_n, ramen_n, mfpen_n, expen_n}), 32'hF);
        as_n = 1'b0;
        #1;
        check("b2b_cs_on", 32'({romen_n, ramen_n, mfpen_n, expen_n}), 32'(4'b1011));
        tick();
        check("b2b_hold", 32'(dtack_n), 32'd0);
        as_n = 1'b1;
        tick();
        check("b2b_release", 32'(dtack_n), 32'd1);

        // Reset during a ROM wait re-enters the boot overlay
        addr = 12'h380;
        as_n = 1'b0;
        tick();
        check("mrst_wait_dtack", 32'(dtack_n), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrst_cs", 32'({romen_n, ramen_n, mfpen_n, expen_n}), 32'hF);
        tick();
        check("mrst_dtack", 32'(dtack_n), 32'd1);
        check("mrst_berr",  32'(berr_n),  32'd1);
        check("mrst_boot",  32'(boot),    32'd0);
        rst_n = 1'b1;
        as_n  = 1'b1;
        tick();
        run_cycle(12'h200, 1'b1, -1, 1'b0, cs, lat, gb, rel);
        check("mrst_ovl_cs",   32'(cs),   32'(4'b0111));
        check("mrst_ovl_lat",  lat,       32'd2);
        check("mrst_ovl_boot", 32'(boot), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
